// File: rtl/pred_pkg.sv
// ============================================================================
// Module   : pred_pkg
// Brief    : Shared types, counter constants and saturating update helper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pred_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_STRONG_NT = 2'd0;
  localparam cnt_t CNT_WEAK_NT   = 2'd1;
  localparam cnt_t CNT_WEAK_T    = 2'd2;
  localparam cnt_t CNT_STRONG_T  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } req_state_t;

  // Two-bit counter that clamps at both ends instead of wrapping.
  function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
    if (taken)
      return (cnt == CNT_STRONG_T) ? cnt : cnt_t'(cnt + 2'd1);
    else
      return (cnt == CNT_STRONG_NT) ? cnt : cnt_t'(cnt - 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting at ptr, wrapping mod N
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  logic [PW-1:0] w_cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = PW'((int'(ptr) + k) % N);
      if (!any && elig[w_cand]) begin
        any         = 1'b1;
        win[w_cand] = 1'b1;
        win_idx     = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pred_share_ctrl.sv
// ============================================================================
// Module   : pred_share_ctrl
// Brief    : Shared 2-bit counter table, round-robin predict / fixed-priority
//            result arbitration across NREQ requesters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pred_share_ctrl
  import pred_pkg::*;
#(
  parameter int   NREQ     = 4,
  parameter int   IDX_W    = 4,
  parameter cnt_t CNT_INIT = CNT_STRONG_T
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*IDX_W-1:0] req_idx,
  output logic [NREQ-1:0]       grant,
  output logic                  pred_valid,
  output logic                  prediction,
  input  logic [NREQ-1:0]       res,
  input  logic [NREQ-1:0]       res_taken,
  output logic [NREQ-1:0]       res_ack,
  output logic [NREQ-1:0]       busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int PW    = $clog2(NREQ);

  cnt_t             r_cnt   [DEPTH];
  req_state_t       r_state [NREQ];
  logic [IDX_W-1:0] r_idx_q [NREQ];
  logic [PW-1:0]    r_ptr;

  logic [NREQ-1:0]  w_pelig, w_relig, w_pwin, w_rwin;
  logic [PW-1:0]    w_psel, w_rsel;
  logic             w_pany, w_rany;
  logic [IDX_W-1:0] w_pidx, w_rtbl;
  cnt_t             w_pcnt, w_rnew;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign w_pelig[i] = req[i] && (r_state[i] == ST_IDLE);
    assign w_relig[i] = res[i] && (r_state[i] == ST_WAIT);
    assign busy[i]    = (r_state[i] == ST_WAIT);
  end

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .elig    (w_pelig),
    .ptr     (r_ptr),
    .win     (w_pwin),
    .win_idx (w_psel),
    .any     (w_pany)
  );

  always_comb begin
    w_rwin = '0;
    w_rsel = '0;
    w_rany = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_rany && w_relig[i]) begin
        w_rany    = 1'b1;
        w_rwin[i] = 1'b1;
        w_rsel    = PW'(i);
      end
    end
  end

  // Both paths read the table as it stood before this edge, giving read-before-write.
  assign w_pidx = req_idx[w_psel*IDX_W +: IDX_W];
  assign w_pcnt = r_cnt[w_pidx];
  assign w_rtbl = r_idx_q[w_rsel];
  assign w_rnew = sat_update(r_cnt[w_rtbl], res_taken[w_rsel]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DEPTH; d++) r_cnt[d] <= CNT_INIT;
      for (int i = 0; i < NREQ; i++) begin
        r_state[i] <= ST_IDLE;
        r_idx_q[i] <= '0;
      end
      r_ptr      <= '0;
      grant      <= '0;
      res_ack    <= '0;
      pred_valid <= 1'b0;
      prediction <= 1'b0;
    end else begin
      grant      <= w_pwin;
      pred_valid <= w_pany;
      prediction <= w_pany & w_pcnt[1];
      res_ack    <= w_rwin;
      if (w_pany) begin
        r_state[w_psel] <= ST_WAIT;
        r_idx_q[w_psel] <= w_pidx;
        r_ptr           <= (w_psel == PW'(NREQ - 1)) ? '0 : w_psel + 1'b1;
      end
      // Winners are in opposite states, so these never target the same requester.
      if (w_rany) begin
        r_state[w_rsel] <= ST_IDLE;
        r_cnt[w_rtbl]   <= w_rnew;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pred_share_ctrl.sv
// ============================================================================
// Module   : tb_pred_share_ctrl
// Brief    : Directed self-checking bench for pred_share_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pred_share_ctrl;

  localparam int NREQ  = 4;
  localparam int IDX_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, res, res_taken;
  logic [NREQ*IDX_W-1:0] req_idx;
  logic [NREQ-1:0]       grant, res_ack, busy;
  logic                  pred_valid, prediction;

  int compared   = 0;
  int mismatched = 0;
  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic exp_pred [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  pred_share_ctrl #(.NREQ(NREQ), .IDX_W(IDX_W), .CNT_INIT(2'b11)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_idx    (req_idx),
    .grant      (grant),
    .pred_valid (pred_valid),
    .prediction (prediction),
    .res        (res),
    .res_taken  (res_taken),
    .res_ack    (res_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idx(input int i, input logic [IDX_W-1:0] v);
    req_idx[i*IDX_W +: IDX_W] = v;
  endtask

  initial begin
    rst = 1'b1; req = '0; res = '0; res_taken = '0; req_idx = '0;
    tick; tick;
    rst = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_res_ack", res_ack, 0);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_prediction", prediction, 0);
    check("rst_busy", busy, 0);

    // Single request, single grant with 1-cycle latency.
    req[0] = 1'b1; set_idx(0, 4'd5);
    tick;
    check("t1_grant", grant, 4'b0001);
    check("t1_pred_valid", pred_valid, 1);
    check("t1_prediction", prediction, 1);
    check("t1_busy", busy, 4'b0001);
    req[0] = 1'b0;
    tick;
    check("t1_grant_pulse", grant, 0);
    check("t1_pv_pulse", pred_valid, 0);
    res[0] = 1'b1; res_taken[0] = 1'b1;
    tick;
    check("t1_res_ack", res_ack, 4'b0001);
    check("t1_busy_clr", busy, 0);
    res = '0;

    // Round-robin with all requesters held high, pointer reset to 0.
    rst = 1'b1; tick; rst = 1'b0;
    req = 4'b1111; res_taken = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_idx(i, 4'(i));
    for (int k = 0; k < 5; k++) begin
      tick;
      check("t2_rr_grant", grant, 32'd1 << exp_order[k]);
      check("t2_rr_ack", res_ack, (k == 0) ? 32'd0 : (32'd1 << exp_order[k-1]));
      res = grant;
    end
    req = '0;
    tick;
    check("t2_last_ack", res_ack, 4'b0001);
    check("t2_no_grant", grant, 0);
    res = '0;

    // Saturating decrement on idx 3: 3,2,1,0,0.
    for (int r = 0; r < 4; r++) begin
      req[0] = 1'b1; set_idx(0, 4'd3);
      tick;
      check("t3_grant", grant, 4'b0001);
      check("t3_pred", prediction, exp_pred[r]);
      req[0] = 1'b0; res[0] = 1'b1; res_taken[0] = 1'b0;
      tick;
      check("t3_ack", res_ack, 4'b0001);
      res = '0;
    end
    req[0] = 1'b1;
    tick;
    check("t3_floor_pv", pred_valid, 1);
    check("t3_floor_pred", prediction, 0);
    req[0] = 1'b0; res[0] = 1'b1; res_taken[0] = 1'b0;
    tick;
    res = '0;

    // Read-before-write on idx 7 with counter at 2.
    req[2] = 1'b1; set_idx(2, 4'd7);
    tick;
    check("t4_setup_grant", grant, 4'b0100);
    req[2] = 1'b0; res[2] = 1'b1; res_taken[2] = 1'b0;
    tick;
    check("t4_setup_ack", res_ack, 4'b0100);
    res = '0; req[2] = 1'b1;
    tick;
    check("t4_pred_cnt2", prediction, 1);
    req[2] = 1'b0;
    req[1] = 1'b1; set_idx(1, 4'd7); res[2] = 1'b1; res_taken[2] = 1'b0;
    tick;
    check("t4_same_grant", grant, 4'b0010);
    check("t4_same_ack", res_ack, 4'b0100);
    check("t4_same_pred", prediction, 1);
    req = '0; res = '0;
    req[3] = 1'b1; set_idx(3, 4'd7);
    tick;
    check("t4_after_grant", grant, 4'b1000);
    check("t4_after_pred", prediction, 0);
    req = '0;

    // Fixed-priority result arbitration, loser keeps its strobe.
    res = 4'b1010; res_taken = 4'b1010;
    tick;
    check("t5_ack1", res_ack, 4'b0010);
    check("t5_busy1", busy, 4'b1000);
    res[1] = 1'b0;
    tick;
    check("t5_ack3", res_ack, 4'b1000);
    check("t5_busy3", busy, 0);
    res = '0;
    tick;
    check("t5_ack_idle", res_ack, 0);
    req[0] = 1'b1; set_idx(0, 4'd7);
    tick;
    check("t5_pred_cnt3", prediction, 1);
    req[0] = 1'b0; res[0] = 1'b1; res_taken[0] = 1'b1;
    tick;
    res = '0;

    // Reset discards outstanding predictions and restores counters.
    req = 4'b0101; set_idx(0, 4'd3); set_idx(2, 4'd9);
    tick;
    check("t6_grant_a", grant, 4'b0100);
    req[2] = 1'b0;
    tick;
    check("t6_grant_b", grant, 4'b0001);
    check("t6_busy", busy, 4'b0101);
    req = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_grant", grant, 0);
    res[0] = 1'b1;
    tick;
    check("t6_no_ack_a", res_ack, 0);
    tick;
    check("t6_no_ack_b", res_ack, 0);
    res = '0;
    req[0] = 1'b1; set_idx(0, 4'd3);
    tick;
    check("t6_post_grant", grant, 4'b0001);
    check("t6_post_pred", prediction, 1);
    req = '0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
